// File: rtl/dds_phase_accum_pkg.sv
// Shared DDS definitions: default widths, FSM state encoding and phase slice offset.
package dds_pkg;
  localparam int ACC_W     = 24;
  localparam int PHASE_W   = 14;
  localparam int PHASE_LSB = ACC_W - PHASE_W;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } dds_state_e;
endpackage

// File: rtl/dds_phase_accum_if.sv
// Control/status bundle between the frequency controller host and the phase accumulator.
interface dds_phase_accum_if #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 14
);
  import dds_pkg::*;

  // FTW handshake: a word transfers on any rising edge where ftw_valid && ftw_ready.
  // ftw_valid must hold ftw_in/upd_at_wrap stable until that edge; ftw_ready never
  // depends on ftw_valid.
  logic               en;
  logic               phase_clr;
  logic [ACC_W-1:0]   ftw_in;
  logic               ftw_valid;
  logic               ftw_ready;
  logic               upd_at_wrap;
  logic               sweep_en;
  logic [ACC_W-1:0]   sweep_step;
  logic [ACC_W-1:0]   sweep_limit;
  logic [PHASE_W-1:0] phase;
  logic               wrap;
  logic               sweep_done;
  logic [ACC_W-1:0]   ftw_active;
  dds_state_e         dbg_state;

  modport slave (
    input  en, phase_clr, ftw_in, ftw_valid, upd_at_wrap,
    input  sweep_en, sweep_step, sweep_limit,
    output ftw_ready, phase, wrap, sweep_done, ftw_active, dbg_state
  );

  modport master (
    output en, phase_clr, ftw_in, ftw_valid, upd_at_wrap,
    output sweep_en, sweep_step, sweep_limit,
    input  ftw_ready, phase, wrap, sweep_done, ftw_active, dbg_state
  );
endinterface

// File: rtl/dds_ftw_ctrl.sv
// Tuning-word owner: immediate/deferred FTW loads, shadow register and per-wrap linear sweep.
module dds_ftw_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W = dds_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] i_ftw_in,
  input  logic             i_ftw_valid,
  input  logic             i_upd_at_wrap,
  input  logic             i_sweep_en,
  input  logic [ACC_W-1:0] i_sweep_step,
  input  logic [ACC_W-1:0] i_sweep_limit,
  input  logic             i_carry,
  output logic             o_ftw_ready,
  output logic [ACC_W-1:0] o_ftw_active,
  output logic             o_sweep_done,
  output dds_state_e       o_state
);
  dds_state_e       r_state;
  logic [ACC_W-1:0] r_shadow;
  logic [ACC_W-1:0] r_ftw_active;
  logic             r_sweep_done;
  logic [ACC_W:0]   w_sweep_sum;
  logic             w_handshake;

  // Ready is a pure function of state, masked while reset is held.
  assign o_ftw_ready = (r_state == ST_RUN) & ~rst;
  assign w_handshake = i_ftw_valid & o_ftw_ready;
  assign w_sweep_sum = {1'b0, r_ftw_active} + {1'b0, i_sweep_step};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_shadow     <= '0;
      r_ftw_active <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_handshake) begin
            if (i_upd_at_wrap) begin
              r_shadow <= i_ftw_in;
              r_state  <= ST_PENDING;
            end else begin
              r_ftw_active <= i_ftw_in;
            end
          end else if (i_sweep_en && i_carry && (r_ftw_active != i_sweep_limit)) begin
            // Saturate at the ceiling; this also snaps down when the limit is below the FTW.
            if (w_sweep_sum >= {1'b0, i_sweep_limit}) begin
              r_ftw_active <= i_sweep_limit;
              r_sweep_done <= 1'b1;
            end else begin
              r_ftw_active <= w_sweep_sum[ACC_W-1:0];
            end
          end
        end
        ST_PENDING: begin
          if (i_carry) begin
            r_ftw_active <= r_shadow;
            r_state      <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_ftw_active = r_ftw_active;
  assign o_sweep_done = r_sweep_done;
  assign o_state      = r_state;
endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: ACC_W-bit accumulator, carry-based wrap pulse and phase slice.
module dds_phase_accum
  import dds_pkg::*;
#(
  parameter int ACC_W   = dds_pkg::ACC_W,
  parameter int PHASE_W = dds_pkg::PHASE_W
) (
  input logic              clk,
  input logic              rst,
  dds_phase_accum_if.slave bus
);
  logic [ACC_W-1:0] r_acc;
  logic             r_wrap;
  logic [ACC_W:0]   w_sum;
  logic             w_carry_evt;
  logic [ACC_W-1:0] w_ftw_active;

  assign w_sum       = {1'b0, r_acc} + {1'b0, w_ftw_active};
  // A carry only counts as a wrap when the accumulate actually happens.
  assign w_carry_evt = bus.en & ~bus.phase_clr & w_sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (bus.phase_clr) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (bus.en) begin
      r_acc  <= w_sum[ACC_W-1:0];
      r_wrap <= w_sum[ACC_W];
    end else begin
      r_wrap <= 1'b0;
    end
  end

  dds_ftw_ctrl #(
    .ACC_W(ACC_W)
  ) u_ftw_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_ftw_in      (bus.ftw_in),
    .i_ftw_valid   (bus.ftw_valid),
    .i_upd_at_wrap (bus.upd_at_wrap),
    .i_sweep_en    (bus.sweep_en),
    .i_sweep_step  (bus.sweep_step),
    .i_sweep_limit (bus.sweep_limit),
    .i_carry       (w_carry_evt),
    .o_ftw_ready   (bus.ftw_ready),
    .o_ftw_active  (w_ftw_active),
    .o_sweep_done  (bus.sweep_done),
    .o_state       (bus.dbg_state)
  );

  assign bus.phase      = r_acc[ACC_W-1 -: PHASE_W];
  assign bus.wrap       = r_wrap;
  assign bus.ftw_active = w_ftw_active;
endmodule

// File: tb/tb_dds_phase_accum.sv
// Directed bench for dds_phase_accum: FTW loads, deferred update, phase clear, sweep, reset.
module tb_dds_phase_accum;
  import dds_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  logic done_seen;

  dds_phase_accum_if #(.ACC_W(24), .PHASE_W(14)) bus ();

  dds_phase_accum #(.ACC_W(24), .PHASE_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Tick until a wrap pulse (bounded), reporting cycles taken and any sweep_done seen.
  task automatic wait_wrap(output int cyc, output logic done);
    cyc  = 0;
    done = 1'b0;
    do begin
      tick();
      cyc++;
      done = done | bus.sweep_done;
    end while (!bus.wrap && cyc < 64);
  endtask

  initial begin
    rst             = 1'b1;
    bus.en          = 1'b0;
    bus.phase_clr   = 1'b0;
    bus.ftw_in      = '0;
    bus.ftw_valid   = 1'b0;
    bus.upd_at_wrap = 1'b0;
    bus.sweep_en    = 1'b0;
    bus.sweep_step  = '0;
    bus.sweep_limit = '0;

    // 1. reset, then immediate load of 0x000400 -> phase counts 1 per cycle
    tick();
    tick();
    check("rst_phase", 32'(bus.phase), 32'h0);
    check("rst_ftw_active", bus.ftw_active, 32'h0);
    check("rst_wrap", 32'(bus.wrap), 32'h0);
    check("rst_sweep_done", 32'(bus.sweep_done), 32'h0);
    check("rst_ready_held", 32'(bus.ftw_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.ftw_ready), 32'h1);
    bus.ftw_in    = 24'h000400;
    bus.ftw_valid = 1'b1;
    bus.en        = 1'b1;
    tick();
    bus.ftw_valid = 1'b0;
    check("t1_ftw_active", bus.ftw_active, 32'h400);
    check("t1_phase0", 32'(bus.phase), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t1_phase_inc", 32'(bus.phase), 32'(k));
      check("t1_ready", 32'(bus.ftw_ready), 32'h1);
    end

    // 2. 0x100000 -> wrap every 16; deferred 0x200000 -> wrap every 8 after next wrap
    bus.ftw_in    = 24'h100000;
    bus.ftw_valid = 1'b1;
    bus.phase_clr = 1'b1;
    tick();
    bus.ftw_valid = 1'b0;
    bus.phase_clr = 1'b0;
    check("t2_phase_clr", 32'(bus.phase), 32'h0);
    for (int i = 0; i < 32; i++) begin
      tick();
      check("t2_wrap16", 32'(bus.wrap), 32'((i % 16) == 15));
    end
    bus.ftw_in      = 24'h200000;
    bus.upd_at_wrap = 1'b1;
    bus.ftw_valid   = 1'b1;
    tick();
    bus.ftw_valid   = 1'b0;
    bus.upd_at_wrap = 1'b0;
    check("t2_pend_ready", 32'(bus.ftw_ready), 32'h0);
    check("t2_pend_ftw", bus.ftw_active, 32'h100000);
    check("t2_pend_state", 32'(bus.dbg_state), 32'(ST_PENDING));
    for (int k = 0; k < 14; k++) begin
      tick();
      check("t2_pend_nowrap", 32'(bus.wrap), 32'h0);
      check("t2_pend_ready_low", 32'(bus.ftw_ready), 32'h0);
    end
    tick();
    check("t2_defer_wrap", 32'(bus.wrap), 32'h1);
    check("t2_defer_ftw", bus.ftw_active, 32'h200000);
    check("t2_defer_ready", 32'(bus.ftw_ready), 32'h1);
    for (int j = 0; j < 16; j++) begin
      tick();
      check("t2_wrap8", 32'(bus.wrap), 32'((j % 8) == 7));
    end

    // 3. phase_clr while PENDING keeps the shadow
    bus.ftw_in      = 24'h400000;
    bus.upd_at_wrap = 1'b1;
    bus.ftw_valid   = 1'b1;
    tick();
    bus.ftw_valid   = 1'b0;
    bus.upd_at_wrap = 1'b0;
    tick();
    check("t3_phase_pre", 32'(bus.phase), 32'h1000);
    bus.phase_clr = 1'b1;
    tick();
    bus.phase_clr = 1'b0;
    check("t3_clr_phase", 32'(bus.phase), 32'h0);
    check("t3_clr_state", 32'(bus.dbg_state), 32'(ST_PENDING));
    check("t3_clr_ready", 32'(bus.ftw_ready), 32'h0);
    check("t3_clr_wrap", 32'(bus.wrap), 32'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t3_nowrap", 32'(bus.wrap), 32'h0);
    end
    tick();
    check("t3_wrap", 32'(bus.wrap), 32'h1);
    check("t3_ftw", bus.ftw_active, 32'h400000);
    check("t3_state", 32'(bus.dbg_state), 32'(ST_RUN));
    for (int j = 0; j < 4; j++) begin
      tick();
      check("t3_wrap4", 32'(bus.wrap), 32'(j == 3));
    end

    // 4. sweep 0x100000 -> 0x400000 in steps of 0x100000
    bus.ftw_in    = 24'h100000;
    bus.ftw_valid = 1'b1;
    bus.phase_clr = 1'b1;
    tick();
    bus.ftw_valid   = 1'b0;
    bus.phase_clr   = 1'b0;
    bus.sweep_en    = 1'b1;
    bus.sweep_step  = 24'h100000;
    bus.sweep_limit = 24'h400000;
    wait_wrap(n, done_seen);
    check("t4_w1_cycles", 32'(n), 32'd16);
    check("t4_w1_ftw", bus.ftw_active, 32'h200000);
    check("t4_w1_done", 32'(done_seen), 32'h0);
    wait_wrap(n, done_seen);
    check("t4_w2_cycles", 32'(n), 32'd8);
    check("t4_w2_ftw", bus.ftw_active, 32'h300000);
    check("t4_w2_done", 32'(done_seen), 32'h0);
    wait_wrap(n, done_seen);
    check("t4_w3_cycles", 32'(n), 32'd6);
    check("t4_w3_ftw", bus.ftw_active, 32'h400000);
    check("t4_w3_done", 32'(bus.sweep_done), 32'h1);
    wait_wrap(n, done_seen);
    check("t4_w4_cycles", 32'(n), 32'd4);
    check("t4_w4_ftw", bus.ftw_active, 32'h400000);
    check("t4_w4_done", 32'(done_seen), 32'h0);

    // 5. handshake on a sweep wrap edge wins; then ftw=0 freezes phase
    bus.sweep_limit = 24'hF00000;
    tick();
    tick();
    tick();
    check("t5_pre_nowrap", 32'(bus.wrap), 32'h0);
    bus.ftw_in    = 24'h080000;
    bus.ftw_valid = 1'b1;
    tick();
    bus.ftw_valid = 1'b0;
    check("t5_wrap", 32'(bus.wrap), 32'h1);
    check("t5_ftw_hs", bus.ftw_active, 32'h080000);
    check("t5_no_done", 32'(bus.sweep_done), 32'h0);
    bus.sweep_en  = 1'b0;
    bus.ftw_in    = 24'h0;
    bus.ftw_valid = 1'b1;
    tick();
    bus.ftw_valid = 1'b0;
    check("t5_ftw_zero", bus.ftw_active, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_phase_hold", 32'(bus.phase), 32'hA00);
      check("t5_nowrap", 32'(bus.wrap), 32'h0);
    end

    // 6. reset while PENDING with acc=0x123456
    bus.ftw_in    = 24'h123456;
    bus.ftw_valid = 1'b1;
    bus.phase_clr = 1'b1;
    tick();
    bus.phase_clr   = 1'b0;
    bus.ftw_in      = 24'h111111;
    bus.upd_at_wrap = 1'b1;
    tick();
    bus.ftw_valid   = 1'b0;
    bus.upd_at_wrap = 1'b0;
    bus.en          = 1'b0;
    check("t6_phase", 32'(bus.phase), 32'h48D);
    check("t6_pend", 32'(bus.dbg_state), 32'(ST_PENDING));
    rst = 1'b1;
    tick();
    check("t6_rst_phase", 32'(bus.phase), 32'h0);
    check("t6_rst_ftw", bus.ftw_active, 32'h0);
    check("t6_rst_state", 32'(bus.dbg_state), 32'(ST_RUN));
    rst = 1'b0;
    #1;
    check("t6_rst_ready", 32'(bus.ftw_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dds_phase_accum.md
Name: dds_phase_accum

Overview:
Phase accumulator and frequency-control stage of the DDS chain. It sits directly upstream of the sine lookup stage and drives that stage's phase input with the top PHASE_W bits of an ACC_W-bit accumulator. It owns the frequency tuning word (FTW), which can be loaded immediately or deferred to a phase wrap, plus an optional per-wrap linear frequency sweep.

Parameters:
ACC_W, 24, accumulator and FTW width in bits
PHASE_W, 14, output phase width; must match the lookup stage input width; PHASE_W <= ACC_W

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous active-high reset
en  in  1  accumulate enable
phase_clr  in  1  synchronous clear of the accumulator
ftw_in  in  ACC_W  new tuning word
ftw_valid  in  1  ftw_in is valid
ftw_ready  out  1  block can accept an FTW
upd_at_wrap  in  1  0: apply FTW immediately; 1: defer the FTW to the next wrap; sampled with the handshake
sweep_en  in  1  enable linear sweep
sweep_step  in  ACC_W  FTW increment applied per wrap
sweep_limit  in  ACC_W  FTW ceiling for the sweep
phase  out  PHASE_W  acc[ACC_W-1 -: PHASE_W], to the lookup stage
wrap  out  1  one-cycle pulse on accumulator carry-out
sweep_done  out  1  one-cycle pulse when the FTW reaches sweep_limit
ftw_active  out  ACC_W  FTW currently in use

Behaviour:
- Reset (rst=1 at an edge): acc=0, ftw_active=0, shadow=0, state=RUN, wrap=0, sweep_done=0, ftw_ready=0 during the reset cycle, and ftw_ready=1 from the first cycle after reset.
- Accumulator:
  - If phase_clr, acc<=0 and wrap<=0. phase_clr has priority over en.
  - Else if en, {carry, acc} <= acc + ftw_active, using modulo 2^ACC_W arithmetic, and wrap<=carry.
  - Else acc holds and wrap<=0.
  - phase is a direct slice of the acc register, so phase changes 1 cycle after the edge on which en is sampled high.
- FSM states are RUN and PENDING.
  - RUN: ftw_ready=1. On ftw_valid&&ftw_ready:
    - If upd_at_wrap=0, ftw_active<=ftw_in at the same edge, and the new FTW is used by the next accumulate.
    - Else shadow<=ftw_in and go to PENDING.
  - PENDING: ftw_ready=0. At the edge where carry=1 (en=1, no phase_clr), ftw_active<=shadow and go to RUN. The accumulate at that edge still uses the old FTW.
- phase_clr in PENDING does not discard the shadow; the FSM stays in PENDING.
- Sweep is active only when sweep_en=1 and state=RUN with no handshake at the same edge. A handshake has priority over the sweep.
  - On each carry=1 edge: if ftw_active + sweep_step >= sweep_limit (ACC_W+1-bit compare), then ftw_active<=sweep_limit and sweep_done pulses once.
  - Otherwise ftw_active<=ftw_active+sweep_step.
  - Once ftw_active == sweep_limit, no further update occurs and no further sweep_done pulses.
  - If sweep_limit < ftw_active when the sweep starts, ftw_active snaps to sweep_limit at the first wrap.
- ftw_ready depends only on state; it has no combinational path from ftw_valid.
- ftw_active=0 with en=1: acc holds its value and wrap never fires.
- A reset mid-PENDING discards the shadow and returns to RUN.

Decomposition:
- Shared package dds_pkg holds: ACC_W/PHASE_W defaults, the FSM state encoding (ST_RUN, ST_PENDING), and a phase-slice helper constant (PHASE_LSB = ACC_W-PHASE_W).
- One sub-module, dds_ftw_ctrl: the FSM, shadow register, sweep adder/compare and ftw_active.
- The top level keeps the accumulator, the wrap generation and the phase slice.

Test Plan:
1. Reset, then load ftw 0x000400 (upd_at_wrap=0) with en=1 -> phase increments by 1 each cycle (0,1,2,...); ftw_ready=1 throughout.
2. Load ftw 0x100000 -> wrap pulses exactly every 16 cycles. Then a deferred load of 0x200000 -> ftw_ready=0 until the next wrap, after which wrap fires every 8 cycles.
3. Assert phase_clr with en=1 while PENDING -> phase=0 the next cycle; state stays PENDING; the new FTW is applied at the next wrap.
4. Sweep: ftw 0x100000, step 0x100000, limit 0x400000 -> ftw_active steps 0x200000, 0x300000, 0x400000 on successive wraps; a single sweep_done pulse occurs on the third wrap, with no pulse after.
5. Handshake at the same edge as a sweep wrap -> ftw_active=ftw_in and the sweep increment is dropped. Then ftw=0 -> phase holds and wrap=0.
6. rst mid-PENDING with acc=0x123456 -> next cycle acc=0, ftw_active=0, ftw_ready=1, phase=0.
